// File: rtl/led_scanner_if.sv
// Control and status bundle for the LED scanner: run/mode/direction/speed
// controls in, LED pattern, current direction and step strobe out.
interface led_scanner_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             mode;
    logic             dir_in;
    logic [1:0]       speed;
    logic [WIDTH-1:0] shift_out;
    logic             dir;
    logic             tick;

    modport master (
        output en, mode, dir_in, speed,
        input  shift_out, dir, tick
    );

    modport slave (
        input  en, mode, dir_in, speed,
        output shift_out, dir, tick
    );
endinterface

// File: rtl/led_scanner.sv
// LED scanner: a WIN-wide lit window walks across WIDTH LEDs, either
// bouncing between the two ends or rotating with wrap-around. Steps are
// paced by a free-running prescaler whose tap is chosen by speed.
//
// state   | meaning
// DIR_LSB | window moving toward bit 0
// DIR_MSB | window moving toward bit WIDTH-1
module led_scanner #(
    parameter int WIDTH    = 8,
    parameter int WIN      = 3,
    parameter int DIV_BITS = 20
) (
    input  logic          clk,
    input  logic          reset,
    led_scanner_if.slave  bus
);

    localparam int PW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int TOP = WIDTH - WIN;

    localparam logic [PW-1:0]       POS_ZERO  = '0;
    localparam logic [PW-1:0]       POS_ONE   = PW'(1);
    localparam logic [PW-1:0]       POS_LAST  = PW'(WIDTH - 1);
    localparam logic [PW-1:0]       POS_RST   = PW'(TOP);
    localparam logic [WIDTH-1:0]    SHIFT_RST = ~({WIDTH{1'b1}} >> WIN);
    localparam logic [DIV_BITS-1:0] CNT_ONE   = DIV_BITS'(1);

    typedef enum logic {
        DIR_LSB = 1'b0,
        DIR_MSB = 1'b1
    } dir_e;

    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic [DIV_BITS-1:0] tick_mask;
    logic [PW-1:0]       pos_q, pos_d;
    dir_e                dir_q, dir_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic                tick;

    // Lit window for a given position, wrapping past the MSB back to bit 0.
    function automatic logic [WIDTH-1:0] window(input logic [PW-1:0] p);
        logic [WIDTH-1:0] w;
        int               idx;
        w = '0;
        for (int k = 0; k < WIN; k++) begin
            idx = int'(p) + k;
            if (idx >= WIDTH) begin
                idx = idx - WIDTH;
            end
            w[idx] = 1'b1;
        end
        return w;
    endfunction

    // Step strobe: low (DIV_BITS-speed) prescaler bits all ones while running.
    always_comb begin
        tick_mask = {DIV_BITS{1'b1}} >> bus.speed;
        tick      = reset & bus.en & ((cnt_q & tick_mask) == tick_mask);
        cnt_d     = bus.en ? (cnt_q + CNT_ONE) : cnt_q;
    end

    // Next position/direction; only a tick moves anything.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (tick) begin
            if (!bus.mode) begin
                if (int'(pos_q) > TOP) begin
                    // Coming out of rotate beyond the bounce range: park at the top end.
                    pos_d = POS_RST;
                    dir_d = DIR_LSB;
                end else if (TOP == 0) begin
                    // Window fills the whole bar; only the direction flips.
                    dir_d = (dir_q == DIR_LSB) ? DIR_MSB : DIR_LSB;
                end else if (dir_q == DIR_LSB) begin
                    if (pos_q != POS_ZERO) begin
                        pos_d = pos_q - POS_ONE;
                    end else begin
                        pos_d = POS_ONE;
                        dir_d = DIR_MSB;
                    end
                end else begin
                    if (int'(pos_q) < TOP) begin
                        pos_d = pos_q + POS_ONE;
                    end else begin
                        pos_d = pos_q - POS_ONE;
                        dir_d = DIR_LSB;
                    end
                end
            end else begin
                dir_d = dir_e'(bus.dir_in);
                if (bus.dir_in) begin
                    pos_d = (pos_q == POS_LAST) ? POS_ZERO : (pos_q + POS_ONE);
                end else begin
                    pos_d = (pos_q == POS_ZERO) ? POS_LAST : (pos_q - POS_ONE);
                end
            end
        end
        shift_d = window(pos_d);
    end

    // State registers; reset parks the window at the MSB end heading toward LSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            pos_q   <= POS_RST;
            dir_q   <= DIR_LSB;
            shift_q <= SHIFT_RST;
        end else begin
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            shift_q <= shift_d;
        end
    end

    assign bus.shift_out = shift_q;
    assign bus.dir       = dir_q;
    assign bus.tick      = tick;

endmodule

// File: doc/led_scanner.md
LED_SCANNER -- requirements
Module: led_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of LED outputs; legal range WIDTH >= 2.
REQ-002 SHALL have parameter WIN, default 3, number of adjacent lit LEDs; legal range 1 <= WIN <= WIDTH.
REQ-003 SHALL have parameter DIV_BITS, default 20, prescaler counter width; legal range DIV_BITS >= 4.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: 1 = run, 0 = freeze.
REQ-007 SHALL have port mode, input, 1 bit: 0 = bounce, 1 = rotate.
REQ-008 SHALL have port dir_in, input, 1 bit: rotate direction; 0 = toward LSB, 1 = toward MSB.
REQ-009 SHALL have port speed, input, 2 bits: step-rate select.
REQ-010 SHALL have port shift_out, output, WIDTH bits: LED pattern, registered.
REQ-011 SHALL have port dir, output, 1 bit: current direction, registered; 0 = toward LSB.
REQ-012 SHALL have port tick, output, 1 bit: step strobe, one clk cycle wide.

Function
REQ-013 SHALL keep an internal DIV_BITS-bit counter that increments by 1 per clk while en=1, holds while en=0, and wraps modulo 2^DIV_BITS.
REQ-014 SHALL assert tick combinationally when en=1 and the low (DIV_BITS-speed) counter bits are all ones, giving a step period of 2^(DIV_BITS-speed) clk cycles.
REQ-015 SHALL apply a speed change to the next tick without clearing the counter.
REQ-016 SHALL hold a position register pos; shift_out bit i SHALL be 1 if and only if i = (pos+k) mod WIDTH for some k in 0..WIN-1.
REQ-017 SHALL update pos and dir only on a rising clk edge where tick=1; otherwise both SHALL hold.
REQ-018 Bounce, dir=0: SHALL set pos to pos-1 if pos>0; if pos=0 it SHALL set dir to 1 and pos to 1.
REQ-019 Bounce, dir=1: SHALL set pos to pos+1 if pos<WIDTH-WIN; if pos=WIDTH-WIN it SHALL set dir to 0 and pos to pos-1.
REQ-020 Bounce with WIDTH=WIN: SHALL keep pos at 0 and toggle dir on every tick.
REQ-021 Rotate: SHALL set dir to dir_in on each tick, then set pos to (pos-1) mod WIDTH if dir_in=0, or (pos+1) mod WIDTH if dir_in=1; the window SHALL wrap across bit 0 and bit WIDTH-1.
REQ-022 SHALL sample mode only on ticks.
REQ-023 On a tick with mode=0 and pos>WIDTH-WIN: SHALL set pos to WIDTH-WIN and dir to 0, with no other movement on that tick.
REQ-024 SHALL keep the number of 1s in shift_out equal to WIN at all times after reset.

Reset
REQ-025 When reset=0, SHALL immediately, without waiting for clk, set counter=0, pos=WIDTH-WIN, dir=0 and shift_out to its WIN most significant bits set (8'b1110_0000 at the defaults).
REQ-026 While reset=0, SHALL hold all state and keep tick low.
REQ-027 On a reset assertion mid-step, SHALL discard any pending step; after release, the first tick SHALL occur 2^(DIV_BITS-speed) clk cycles later.

Verification (WIDTH=8, WIN=3, DIV_BITS=4, speed=0, so 16 clk cycles per step, unless stated)
REQ-028 Reset: assert reset=0 between clk edges -> shift_out=1110_0000, dir=0, tick=0 at once; release -> first tick at 16th clk.
REQ-029 Full bounce, mode=0, en=1: 12 ticks -> 01110000, 00111000, 00011100, 00001110, 00000111, 00001110 (dir=1), 00011100, 00111000, 01110000, 11100000, 01110000 (dir=0), 00111000.
REQ-030 Rotate wrap: mode=1, dir_in=0, 7 ticks from reset -> 7th pattern = 1100_0001; then set dir_in=1 -> next tick gives 1000_0011 and dir=1.
REQ-031 Clamp: rotate to pos=7 (pattern 1000_0011), set mode=0 -> next tick gives 1110_0000, dir=0.
REQ-032 Freeze and speed: en=0 for 50 cycles -> tick stays 0 and shift_out is unchanged; en=1 with speed=3 -> tick every 2 clk cycles; WIDTH=WIN=4 bounce -> shift_out=1111 constant and dir toggles on each tick.
